// File: rtl/rs_int_multi_pkg.sv
// Shared constants and the per-entry record for the integer reservation station.
// Declarations only; no latency.
// No flow control of its own.
package rs_int_multi_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 6;
    localparam int RS_OP_W   = 5;
    localparam int RS_IMM_W  = 16;

    // Producer tag meaning "operand already available".
    localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

    // Opcode bit that selects the immediate as the second operand.
    localparam int IMM_BIT = RS_OP_W - 1;

    typedef struct packed {
        logic                 valid;
        logic [RS_DATA_W-1:0] vj;
        logic [RS_TAG_W-1:0]  qj;
        logic [RS_DATA_W-1:0] vk;
        logic [RS_TAG_W-1:0]  qk;
        logic [RS_OP_W-1:0]   op;
        logic [RS_IMM_W-1:0]  imm;
        logic [RS_TAG_W-1:0]  tag;
    } rs_entry_t;

endpackage

// File: rtl/rs_int_multi_if.sv
// Dispatch, CDB snoop and issue bundle of the integer reservation station.
// Wires only; no latency.
// Dispatch and issue use valid/ready; CDB has no backpressure.
interface rs_int_multi_if #(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int IMM_W   = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_vj;
    logic [DATA_W-1:0]         in_vk;
    logic [TAG_W-1:0]          in_qj;
    logic [TAG_W-1:0]          in_qk;
    logic [OP_W-1:0]           in_op;
    logic [IMM_W-1:0]          in_imm;
    logic [TAG_W-1:0]          in_tag;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic                      issue_valid;
    logic                      issue_ready;
    logic [OP_W-1:0]           issue_op;
    logic [DATA_W-1:0]         issue_a;
    logic [DATA_W-1:0]         issue_b;
    logic [TAG_W-1:0]          issue_tag;
    logic [CNT_W-1:0]          free_count;

    modport master (
        output flush, in_valid, in_vj, in_vk, in_qj, in_qk, in_op, in_imm, in_tag,
        output cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  in_ready, issue_valid, issue_op, issue_a, issue_b, issue_tag, free_count
    );

    modport slave (
        input  flush, in_valid, in_vj, in_vk, in_qj, in_qk, in_op, in_imm, in_tag,
        input  cdb_valid, cdb_tag, cdb_data, issue_ready,
        output in_ready, issue_valid, issue_op, issue_a, issue_b, issue_tag, free_count
    );
endinterface

// File: rtl/rs_int_multi_entry.sv
// One reservation-station slot: operand storage plus CDB compare and capture.
// Capture and wakeup are registered; ready reflects registered tags only.
// No backpressure; alloc/clear are issued by the owning station.
module rs_int_multi_entry
    import rs_int_multi_pkg::*;
#(
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 5,
    parameter int IMM_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      alloc,
    input  logic                      clear,
    input  logic [DATA_W-1:0]         in_vj,
    input  logic [DATA_W-1:0]         in_vk,
    input  logic [TAG_W-1:0]          in_qj,
    input  logic [TAG_W-1:0]          in_qk,
    input  logic [OP_W-1:0]           in_op,
    input  logic [IMM_W-1:0]          in_imm,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output rs_entry_t                 ent,
    output logic                      ready
);

    logic [TAG_W-1:0]  in_qk_eff;
    logic [TAG_W-1:0]  qj_look;
    logic [TAG_W-1:0]  qk_look;
    logic              hit_j;
    logic              hit_k;
    logic [DATA_W-1:0] dat_j;
    logic [DATA_W-1:0] dat_k;

    // Snoop the tags being written (dispatch) or held (wakeup); the lowest bus index wins.
    always_comb begin
        in_qk_eff = in_op[IMM_BIT] ? TAG_NONE : in_qk;
        qj_look   = alloc ? in_qj : ent.qj;
        qk_look   = alloc ? in_qk_eff : ent.qk;
        hit_j     = 1'b0;
        hit_k     = 1'b0;
        dat_j     = '0;
        dat_k     = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && qj_look != TAG_NONE && cdb_tag[i*TAG_W +: TAG_W] == qj_look) begin
                hit_j = 1'b1;
                dat_j = cdb_data[i*DATA_W +: DATA_W];
            end
            if (cdb_valid[i] && qk_look != TAG_NONE && cdb_tag[i*TAG_W +: TAG_W] == qk_look) begin
                hit_k = 1'b1;
                dat_k = cdb_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Slot state: flush beats everything, then allocate, then issue, then wakeup.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            ent <= '0;
        end else if (alloc) begin
            ent.valid <= 1'b1;
            ent.op    <= in_op;
            ent.imm   <= in_imm;
            ent.tag   <= in_tag;
            ent.qj    <= hit_j ? TAG_NONE : in_qj;
            ent.vj    <= hit_j ? dat_j : in_vj;
            ent.qk    <= hit_k ? TAG_NONE : in_qk_eff;
            ent.vk    <= hit_k ? dat_k : in_vk;
        end else if (clear) begin
            ent.valid <= 1'b0;
        end else if (ent.valid) begin
            if (hit_j) begin
                ent.qj <= TAG_NONE;
                ent.vj <= dat_j;
            end
            if (hit_k) begin
                ent.qk <= TAG_NONE;
                ent.vk <= dat_k;
            end
        end
    end

    assign ready = ent.valid && (ent.qj == TAG_NONE) && (ent.qk == TAG_NONE);

endmodule

// File: rtl/rs_int_multi.sv
// Multi-entry integer reservation station issuing the oldest operand-complete op.
// Dispatch-to-issue latency 1 cycle; issue outputs are combinational from state.
// in_ready drops when full; an unaccepted issue holds until an older entry becomes ready.
module rs_int_multi
    import rs_int_multi_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OP_W    = RS_OP_W,
    parameter int IMM_W   = RS_IMM_W
) (
    input  logic          clk,
    input  logic          reset,
    rs_int_multi_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        ent [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_rdy;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] sel_oh;
    // older[i][j] set: entry j was allocated before entry i.
    logic [DEPTH-1:0] older [DEPTH];
    logic [CNT_W-1:0] free_cnt;
    logic             disp;
    logic             issue_fire;

    assign disp           = bus.in_valid && bus.in_ready && !bus.flush;
    assign issue_fire     = bus.issue_valid && bus.issue_ready && !bus.flush;
    assign bus.in_ready   = (free_cnt != '0);
    assign bus.free_count = free_cnt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_int_multi_entry #(
            .NUM_CDB (NUM_CDB),
            .TAG_W   (TAG_W),
            .DATA_W  (DATA_W),
            .OP_W    (OP_W),
            .IMM_W   (IMM_W)
        ) u_ent (
            .clk       (clk),
            .reset     (reset),
            .flush     (bus.flush),
            .alloc     (alloc_oh[g]),
            .clear     (sel_oh[g] && issue_fire),
            .in_vj     (bus.in_vj),
            .in_vk     (bus.in_vk),
            .in_qj     (bus.in_qj),
            .in_qk     (bus.in_qk),
            .in_op     (bus.in_op),
            .in_imm    (bus.in_imm),
            .in_tag    (bus.in_tag),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_data  (bus.cdb_data),
            .ent       (ent[g]),
            .ready     (ent_rdy[g])
        );
        assign ent_vld[g] = ent[g].valid;
    end

    // Lowest-index free slot receives the dispatch.
    always_comb begin
        alloc_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_vld[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = disp;
            end
        end
    end

    // New entry becomes younger than everything live; stale bits of a reused slot are cleared.
    always_ff @(posedge clk) begin
        if (!reset || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (disp) begin
            for (int i = 0; i < DEPTH; i++)
                older[i] <= alloc_oh[i] ? ent_vld : (older[i] & ~alloc_oh);
        end
    end

    // Oldest ready entry: ready with no ready entry older than it.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < DEPTH; i++)
            sel_oh[i] = ent_rdy[i] && !(|(older[i] & ent_rdy));
    end

    // Present the selected entry; all zeros when nothing is ready.
    always_comb begin
        bus.issue_valid = |sel_oh;
        bus.issue_op    = '0;
        bus.issue_a     = '0;
        bus.issue_b     = '0;
        bus.issue_tag   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                bus.issue_op  = ent[i].op;
                bus.issue_a   = ent[i].vj;
                bus.issue_b   = ent[i].op[IMM_BIT] ?
                                {{(DATA_W-IMM_W){ent[i].imm[IMM_W-1]}}, ent[i].imm} : ent[i].vk;
                bus.issue_tag = ent[i].tag;
            end
        end
    end

    // Free slots: minus an accepted dispatch, plus an accepted issue.
    always_ff @(posedge clk) begin
        if (!reset || bus.flush)
            free_cnt <= CNT_W'(DEPTH);
        else
            free_cnt <= free_cnt - CNT_W'(disp) + CNT_W'(issue_fire);
    end

endmodule

// File: tb/tb_rs_int_multi.sv
// Scoreboard bench for rs_int_multi against an in-order queue reference model.
// Driver advances one cycle per call; monitor checks 2 time units after each falling edge.
// Exercises dispatch backpressure when full and issue_ready stalls.
module tb_rs_int_multi;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [5:0]  qj;
        logic [5:0]  qk;
        logic [15:0] imm;
        logic [5:0]  tag;
    } ment_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
    } txn_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] free;
        logic       rdy;
        logic       fire;
        txn_t       shown;
    } stat_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    ment_t model [$];   // live entries, oldest first
    stat_t stat_q [$];
    txn_t  txn_q [$];

    rs_int_multi_if bus ();

    rs_int_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic ment_t mk(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [5:0] qj, input logic [5:0] qk, input logic [15:0] imm,
                                 input logic [5:0] tag);
        ment_t m;
        m.op = op; m.vj = vj; m.vk = vk; m.qj = qj; m.qk = qk; m.imm = imm; m.tag = tag;
        return m;
    endfunction

    function automatic txn_t mk_txn(input ment_t m);
        txn_t t;
        t.op  = m.op;
        t.a   = m.vj;
        t.b   = m.op[4] ? {{16{m.imm[15]}}, m.imm} : m.vk;
        t.tag = m.tag;
        return t;
    endfunction

    // First valid bus carrying a non-zero tag equal to q supplies the value.
    function automatic void snoop(input logic [5:0] q, input logic [2:0] cv, input logic [17:0] ct,
                                  input logic [95:0] cd, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (q != 6'd0)
            for (int i = 0; i < 3; i++)
                if (!hit && cv[i] && ct[i*6 +: 6] == q) begin
                    hit = 1'b1;
                    d   = cd[i*32 +: 32];
                end
    endfunction

    // Called at a falling edge: record expectations for this cycle, drive, advance model.
    task automatic step(input logic iv, input ment_t d, input logic [2:0] cv, input logic [17:0] ct,
                        input logic [95:0] cd, input logic ir, input logic fl);
        int          sel;
        stat_t       s;
        txn_t        t;
        bit          can;
        bit          h;
        logic [31:0] dv;
        ment_t       n;
        sel = -1;
        foreach (model[i]) if (sel < 0 && model[i].qj == 6'd0 && model[i].qk == 6'd0) sel = i;
        t = '0;
        if (sel >= 0) t = mk_txn(model[sel]);
        s.vld   = (sel >= 0);
        s.free  = 3'(4 - model.size());
        s.rdy   = (model.size() < 4);
        s.fire  = (sel >= 0) && ir;
        s.shown = t;
        stat_q.push_back(s);
        if (s.fire) txn_q.push_back(t);

        bus.in_valid = iv;    bus.in_vj = d.vj;   bus.in_vk = d.vk;
        bus.in_qj = d.qj;     bus.in_qk = d.qk;   bus.in_op = d.op;
        bus.in_imm = d.imm;   bus.in_tag = d.tag;
        bus.cdb_valid = cv;   bus.cdb_tag = ct;   bus.cdb_data = cd;
        bus.issue_ready = ir; bus.flush = fl;

        can = (model.size() < 4);
        if (fl) begin
            model.delete();
        end else begin
            if (s.fire) model.delete(sel);
            foreach (model[i]) begin
                snoop(model[i].qj, cv, ct, cd, h, dv);
                if (h) begin model[i].qj = 6'd0; model[i].vj = dv; end
                snoop(model[i].qk, cv, ct, cd, h, dv);
                if (h) begin model[i].qk = 6'd0; model[i].vk = dv; end
            end
            if (iv && can) begin
                n = d;
                if (n.op[4]) n.qk = 6'd0;
                snoop(n.qj, cv, ct, cd, h, dv);
                if (h) begin n.qj = 6'd0; n.vj = dv; end
                snoop(n.qk, cv, ct, cd, h, dv);
                if (h) begin n.qk = 6'd0; n.vk = dv; end
                model.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ir);
        step(1'b0, mk(0, 0, 0, 0, 0, 0, 0), 3'b000, 18'd0, 96'd0, ir, 1'b0);
    endtask

    // Monitor: compare DUT presentation and accepted issues against the scoreboard.
    initial begin
        stat_t s;
        txn_t  t;
        forever begin
            @(negedge clk);
            #2;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("issue_valid", bus.issue_valid, s.vld);
                check("free_count", bus.free_count, s.free);
                check("in_ready", bus.in_ready, s.rdy);
                check("issue_outputs", {bus.issue_op, bus.issue_a, bus.issue_b, bus.issue_tag}, s.shown);
                if (s.fire) begin
                    t = txn_q.pop_front();
                    check("issued_txn", {bus.issue_op, bus.issue_a, bus.issue_b, bus.issue_tag}, t);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        ment_t       d;
        logic [17:0] ct;
        reset = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_vj = 0; bus.in_vk = 0; bus.in_qj = 0; bus.in_qk = 0;
        bus.in_op = 0; bus.in_imm = 0; bus.in_tag = 0; bus.cdb_valid = 0; bus.cdb_tag = 0;
        bus.cdb_data = 0; bus.issue_ready = 0;
        repeat (3) @(negedge clk);
        check("reset_free", bus.free_count, 4);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_issue_valid", bus.issue_valid, 0);
        check("reset_issue_zero", {bus.issue_op, bus.issue_a, bus.issue_b, bus.issue_tag}, 0);
        reset = 1'b1;

        // Ready-at-dispatch op issues one cycle later.
        step(1, mk(5'b00010, 5, 7, 0, 0, 0, 3), 0, 0, 0, 0, 0);
        check("t1_valid", bus.issue_valid, 1);
        check("t1_a", bus.issue_a, 5);
        check("t1_b", bus.issue_b, 7);
        check("t1_tag", bus.issue_tag, 3);
        idle(1);
        check("t1_free_after", bus.free_count, 4);

        // Wakeup via CDB1 two cycles after dispatch.
        step(1, mk(5'b00011, 32'h99, 1, 9, 0, 0, 5), 0, 0, 0, 1, 0);
        check("t2_wait0", bus.issue_valid, 0);
        idle(1);
        check("t2_wait1", bus.issue_valid, 0);
        step(0, mk(0, 0, 0, 0, 0, 0, 0), 3'b010, {6'd0, 6'd9, 6'd0}, {32'd0, 32'h11, 32'd0}, 1, 0);
        check("t2_valid", bus.issue_valid, 1);
        check("t2_a", bus.issue_a, 32'h11);
        idle(1);

        // Capture at dispatch from CDB0.
        step(1, mk(5'b00001, 1, 32'h55, 0, 4, 0, 6), 3'b001, {12'd0, 6'd4}, {64'd0, 32'hAA}, 0, 0);
        check("t3_valid", bus.issue_valid, 1);
        check("t3_b", bus.issue_b, 32'hAA);
        idle(1);

        // Fill, stall, then drain in allocation order.
        for (int k = 1; k <= 4; k++) step(1, mk(5'b00100, k, k, 0, 0, 0, 6'(k)), 0, 0, 0, 0, 0);
        check("t4_in_ready", bus.in_ready, 0);
        check("t4_tag_hold", bus.issue_tag, 1);
        step(1, mk(5'b00100, 9, 9, 0, 0, 0, 9), 0, 0, 0, 0, 0);
        check("t4_tag_hold2", bus.issue_tag, 1);
        idle(1);
        check("t4_in_ready_rise", bus.in_ready, 1);
        for (int k = 2; k <= 4; k++) begin
            check("t4_order", bus.issue_tag, k);
            idle(1);
        end
        check("t4_free_end", bus.free_count, 4);

        // Immediate mode ignores qk.
        step(1, mk(5'b10010, 32'h10, 32'h33, 0, 7, 16'hFFFE, 8), 0, 0, 0, 0, 0);
        check("t5_valid", bus.issue_valid, 1);
        check("t5_a", bus.issue_a, 32'h10);
        check("t5_b", bus.issue_b, 32'hFFFFFFFE);
        idle(1);

        // Flush with a concurrent dispatch.
        for (int k = 0; k < 3; k++) step(1, mk(5'b00001, 0, 0, 6'(10 + k), 0, 0, 6'(20 + k)), 0, 0, 0, 0, 0);
        step(1, mk(5'b00001, 1, 2, 0, 0, 0, 23), 0, 0, 0, 1, 1);
        check("t6_free", bus.free_count, 4);
        check("t6_valid", bus.issue_valid, 0);
        step(0, mk(0, 0, 0, 0, 0, 0, 0), 3'b001, {12'd0, 6'd10}, {64'd0, 32'h77}, 1, 0);
        check("t6_no_issue", bus.issue_valid, 0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            d = mk(5'($urandom), $urandom, $urandom,
                   ($urandom % 3 == 0) ? 6'($urandom_range(1, 7)) : 6'd0,
                   ($urandom % 3 == 0) ? 6'($urandom_range(1, 7)) : 6'd0,
                   16'($urandom), 6'($urandom_range(1, 63)));
            for (int i = 0; i < 3; i++) ct[i*6 +: 6] = 6'($urandom_range(0, 7));
            step(($urandom % 3) != 0, d, 3'($urandom), ct, {$urandom, $urandom, $urandom},
                 ($urandom % 4) != 0, ($urandom % 60) == 0);
        end

        step(0, mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1);
        idle(0);
        #3;
        check("scoreboard_drained", txn_q.size(), 0);
        check("status_drained", stat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_int_multi.md
# rs_int_multi

Multi-entry integer reservation station. It replaces the single-slot integer RS in the out-of-order back end. It holds up to DEPTH dispatched integer micro-ops and snoops NUM_CDB common data buses for missing operands. Each cycle it issues the oldest operand-complete entry to a downstream integer ALU through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4: number of entries (≥2).
- NUM_CDB, 3: number of CDB snoop ports.
- TAG_W, 6: ROB/producer tag width; tag 0 means "no dependency".
- DATA_W, 32: operand width.
- OP_W, 5: opcode width; op[OP_W-1]=1 selects immediate mode.
- IMM_W, 16: immediate width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- flush  in  1  mispredict flush; clears all entries.
- in_valid  in  1  dispatch request.
- in_ready  out  1  RS can accept; equals free_count!=0.
- in_vj, in_vk  in  DATA_W  operand values.
- in_qj, in_qk  in  TAG_W  operand producer tags.
- in_op  in  OP_W  opcode.
- in_imm  in  IMM_W  immediate.
- in_tag  in  TAG_W  destination tag.
- cdb_valid  in  NUM_CDB  per-bus result valid.
- cdb_tag  in  NUM_CDB*TAG_W  packed bus tags; bus i at [i*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  packed bus data.
- issue_valid  out  1  an entry is presented.
- issue_ready  in  1  ALU accepts.
- issue_op  out  OP_W  opcode of the presented entry.
- issue_a  out  DATA_W  Vj.
- issue_b  out  DATA_W  Vk, or sign-extended imm in immediate mode.
- issue_tag  out  TAG_W  destination tag.
- free_count  out  $clog2(DEPTH+1)  number of empty entries.

## Operation
- Each entry holds: valid, Vj/Qj, Vk/Qk, op, imm, tag, and age.
- Dispatch (in_valid && in_ready): the lowest-index free entry is written.
  - Qj/Qk are cleared and V loaded when a valid CDB in the same cycle matches a non-zero incoming Q.
  - In immediate mode, Qk is forced to 0 and Vk is ignored.
- Wakeup: for each valid entry with Q!=0, a matching valid CDB clears Q and loads V.
  - If several buses match the same Q, the lowest bus index wins.
- An entry is ready when it is valid and its registered Qj==0 and Qk==0.
- Select: the oldest ready entry is chosen, by allocation order, using a DEPTH×DEPTH age matrix.
  - issue_* outputs are combinational from the selected entry.
  - When issue_valid=0, all issue_* outputs are 0.
- Issue: on issue_valid && issue_ready, the selected entry is invalidated at the clock edge.
  - If issue_ready=0, the selection may change next cycle only if an older entry becomes ready.
- Arithmetic: issue_b = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} in immediate mode. No other computation is done in the RS.
- free_count is updated at each edge as: free − dispatch + issue.

## Timing
- Reset (reset=0) or flush=1 at an edge:
  - all entries become invalid and the age matrix is cleared;
  - free_count=DEPTH, in_ready=1, issue_valid=0;
  - issue outputs are 0.
  - flush overrides in_valid and issue in the same cycle; neither takes effect.
- Dispatch at edge T: the entry is issuable from cycle T+1 if both Q are 0 after capture. Minimum dispatch→issue latency is 1 cycle.
- CDB at edge T wakes the entry; it is issuable in cycle T+1. There is no same-cycle wakeup→issue bypass.
- Full: in_ready=0. A slot freed by issue at edge T can be dispatched into starting at cycle T+1 (no same-cycle reuse).
- Dispatch and issue in the same cycle are allowed when not full; free_count is unchanged.
- Tag 0 on a CDB never wakes an entry, even when cdb_valid=1.

## Structure
- A shared package (`rs_pkg`) holds:
  - the TAG_NONE=0 constant;
  - the immediate-mode opcode bit position;
  - the entry record typedef (valid, v/q pairs, op, imm, tag).
- Sub-module `rs_entry` holds one entry's storage plus the CDB compare/capture logic; it is instantiated DEPTH times.
- Age matrix, free-slot priority encoder and select mux live in the top level.

## Test plan
- Reset, then dispatch op=00010, vj=5, vk=7, q=0, tag=3 → next cycle issue_valid=1, a=5, b=7, tag=3; free_count returns to 4 after issue_ready.
- Dispatch qj=9, then CDB1 tag=9 data=0x11 two cycles later → issue the cycle after capture with a=0x11; no issue before then.
- Dispatch qk=4 while CDB0 tag=4 data=0xAA is valid the same cycle → entry issues next cycle with b=0xAA.
- Fill 4 entries (tags 1–4, all ready), hold issue_ready=0 → in_ready=0, issue_tag=1; release → issue order 1,2,3,4 and in_ready rises the cycle after the first issue.
- Immediate op=10010, vj=0x10, imm=0xFFFE, qk=7 → issues without waiting for tag 7, b=0xFFFFFFFE.
- Three waiting entries, assert flush together with in_valid → next cycle free_count=4 and issue_valid=0; the dispatch is dropped and a later CDB match causes no issue.
